block_transfer_sequencer: RTL

Multi-register memory transfer sequencer for the memory address handler. It takes a 16-bit register list and a base address and issues one word access per selected register, each on a memory ready handshake, using the same hold/increment/decrement/load step codes as the address incrementor. At completion it reports the updated base for register writeback. It sits between the instruction control unit and the data memory port and drives PUSH/POP and LDM/STM style transfers.

---
 rtl/block_transfer_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/block_transfer_sequencer.sv
// rtl/block_transfer_sequencer.sv - multi-register LDM/STM/PUSH/POP transfer sequencer
module block_transfer_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int PACE       = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           register_list,
    input  logic [DATA_WIDTH-1:0] base_address,
    input  logic                  descending,
    input  logic                  writeback,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  access_valid,
    output logic [DATA_WIDTH-1:0] access_address,
    output logic [3:0]            register_index,
    output logic [2:0]            incrementor_control,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] final_address,
    output logic                  writeback_enable
);

    typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;

    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PACE);
    localparam logic [2:0] CTRL_HOLD = 3'd0;
    localparam logic [2:0] CTRL_INC  = 3'd1;
    localparam logic [2:0] CTRL_DEC  = 3'd2;
    localparam logic [2:0] CTRL_LOAD = 3'd4;

    state_t                state, state_next;
    logic [15:0]           list_q, list_next;
    logic [DATA_WIDTH-1:0] ptr_q, ptr_next;
    logic                  desc_q, desc_next;
    logic                  wb_q, wb_next;
    logic [2:0]            ctrl_next;
    logic [3:0]            sel_idx, next_idx;

    // Lowest set bit when ascending, highest set bit when descending.
    function automatic logic [3:0] pick(input logic [15:0] l, input logic d);
        logic [3:0] r;
        r = '0;
        if (d) begin
            for (int i = 0; i < 16; i++)
                if (l[i]) r = 4'(i);
        end else begin
            for (int i = 15; i >= 0; i--)
                if (l[i]) r = 4'(i);
        end
        return r;
    endfunction

    assign sel_idx  = pick(list_q, desc_q);
    assign next_idx = pick(list_next, desc_next);

    // Next-state and step computation; outputs are registered from these below.
    always_comb begin
        state_next = state;
        list_next  = list_q;
        ptr_next   = ptr_q;
        desc_next  = desc_q;
        wb_next    = wb_q;
        ctrl_next  = CTRL_HOLD;
        case (state)
            IDLE: begin
                if (start) begin
                    list_next  = register_list;
                    desc_next  = descending;
                    wb_next    = writeback;
                    ptr_next   = base_address;
                    ctrl_next  = CTRL_LOAD;
                    state_next = (register_list != 16'd0) ? ACCESS : FINISH;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    list_next  = list_q & ~(16'd1 << sel_idx);
                    ptr_next   = desc_q ? (ptr_q - STEP) : (ptr_q + STEP);
                    ctrl_next  = desc_q ? CTRL_DEC : CTRL_INC;
                    state_next = (list_next == 16'd0) ? FINISH : ACCESS;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, context and registered outputs; a stalled access recomputes identical values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            list_q              <= '0;
            ptr_q               <= '0;
            desc_q              <= 1'b0;
            wb_q                <= 1'b0;
            busy                <= 1'b0;
            access_valid        <= 1'b0;
            access_address      <= '0;
            register_index      <= '0;
            incrementor_control <= CTRL_HOLD;
            done                <= 1'b0;
            final_address       <= '0;
            writeback_enable    <= 1'b0;
        end else begin
            state               <= state_next;
            list_q              <= list_next;
            ptr_q               <= ptr_next;
            desc_q              <= desc_next;
            wb_q                <= wb_next;
            busy                <= (state_next != IDLE);
            access_valid        <= (state_next == ACCESS);
            access_address      <= (state_next == ACCESS)
                                   ? (desc_next ? (ptr_next - STEP) : ptr_next) : '0;
            register_index      <= (state_next == ACCESS) ? next_idx : 4'd0;
            incrementor_control <= ctrl_next;
            done                <= (state_next == FINISH);
            final_address       <= (state_next == FINISH) ? ptr_next : '0;
            writeback_enable    <= (state_next == FINISH) && wb_next;
        end
    end

endmodule
